// File: rtl/uart_fifo_core.sv
// uart_fifo_core: 16x-oversampled UART with TX/RX FIFOs, runtime parity,
// sticky error flags and a maskable level interrupt on a zero-wait WISHBONE port.
module uart_fifo_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_RESET  = 161
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [2:0]  ADD_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  input  logic        RxD,
  output logic        TxD,
  output logic        IRQ_O
);
  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [15:0]          div, tick_cnt;
  logic [11:0]          ctrl;
  logic                 tick, fe, pe, ov;
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0]        tx_count, rx_count;
  state_t               tx_state, rx_state;
  logic [3:0]           tx_sub, rx_sub, rx_thr;
  logic [BW-1:0]        tx_bit, rx_bit;
  logic [DATA_BITS-1:0] tx_sh, rx_sh, tx_head, rx_head;
  logic                 tx_par, tx_pen, rx_pen, rx_podd, rx_par_bit;
  logic                 rx_m, rx_s, rx_d, rx_fall;
  logic                 wr, rd, lsr_wr, div_wr, ctrl_wr;
  logic                 tx_push, tx_pop, rx_push, rx_pop;
  logic                 tx_full, rx_full, tx_idle;
  logic                 rx_stop_evt, par_bad, set_fe, set_pe, set_ov;
  logic                 unused_dat;

  assign unused_dat = ^DAT_I[31:16];

  assign wr      = STB_I & WE_I;
  assign rd      = STB_I & ~WE_I;
  assign lsr_wr  = wr & (ADD_I == 3'd1);
  assign div_wr  = wr & (ADD_I == 3'd2);
  assign ctrl_wr = wr & (ADD_I == 3'd3);
  assign ACK_O   = STB_I;

  assign tx_full = (tx_count == CW'(FIFO_DEPTH));
  assign rx_full = (rx_count == CW'(FIFO_DEPTH));
  assign tx_idle = (tx_count == '0) & (tx_state == S_IDLE);
  assign tx_head = tx_mem[tx_rp];
  assign rx_head = rx_mem[rx_rp];

  assign tx_pop  = (tx_state == S_IDLE) & (tx_count != '0);
  assign tx_push = wr & (ADD_I == 3'd0) & (~tx_full | tx_pop);
  assign rx_pop  = rd & (ADD_I == 3'd0) & (rx_count != '0);

  // Stop-bit verdict: frame error beats parity error beats overrun.
  assign rx_stop_evt = (rx_state == S_STOP) & tick & (rx_sub == 4'd15);
  assign par_bad     = rx_pen & (rx_par_bit != (^rx_sh ^ rx_podd));
  assign set_fe      = rx_stop_evt & ~rx_s;
  assign set_pe      = rx_stop_evt & rx_s & par_bad;
  assign set_ov      = rx_stop_evt & rx_s & ~par_bad & rx_full & ~rx_pop;
  assign rx_push     = rx_stop_evt & rx_s & ~par_bad & (~rx_full | rx_pop);
  assign rx_fall     = rx_d & ~rx_s;

  assign tick   = (tick_cnt == div);
  assign rx_thr = (ctrl[11:8] == 4'd0) ? 4'd1 : ctrl[11:8];
  assign IRQ_O  = (ctrl[2] & (9'(rx_count) >= 9'(rx_thr))) | (ctrl[3] & tx_idle) |
                  (ctrl[4] & (fe | pe | ov));

  always_comb begin
    DAT_O = '0;
    case (ADD_I)
      3'd0: DAT_O = (rx_count != '0) ? 32'(rx_head) : 32'd0;
      3'd1: DAT_O = {26'd0, tx_idle, tx_full, ov, pe, fe, (rx_count != '0)};
      3'd2: DAT_O = {16'd0, div};
      3'd3: DAT_O = {20'd0, ctrl};
      3'd4: DAT_O = {7'd0, 9'(tx_count), 7'd0, 9'(rx_count)};
      default: DAT_O = '0;
    endcase
  end

  // Registers, tick generator, sticky flags and RX synchroniser.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      div      <= 16'(DIV_RESET);
      ctrl     <= '0;
      tick_cnt <= '0;
      fe       <= 1'b0;
      pe       <= 1'b0;
      ov       <= 1'b0;
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
    end else begin
      if (div_wr) div <= DAT_I[15:0];
      if (ctrl_wr) ctrl <= DAT_I[11:0] & 12'hF1F;
      if (div_wr || tick) tick_cnt <= '0;
      else tick_cnt <= tick_cnt + 16'd1;
      fe   <= set_fe | (fe & ~lsr_wr);
      pe   <= set_pe | (pe & ~lsr_wr);
      ov   <= set_ov | (ov & ~lsr_wr);
      rx_m <= RxD;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (tx_push) tx_mem[tx_wp] <= DAT_I[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Transmitter; parity settings are latched when a frame starts.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_state <= S_IDLE;
      TxD      <= 1'b1;
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
    end else if (tx_state == S_IDLE) begin
      if (tx_pop) begin
        tx_state <= S_START;
        TxD      <= 1'b0;
        tx_sub   <= '0;
        tx_sh    <= tx_head;
        tx_par   <= ^tx_head ^ ctrl[1];
        tx_pen   <= ctrl[0];
      end
    end else if (tick) begin
      tx_sub <= tx_sub + 4'd1;
      if (tx_sub == 4'd15) begin
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            TxD      <= tx_sh[0];
            tx_bit   <= '0;
          end
          S_DATA: begin
            if (tx_bit == BW'(DATA_BITS - 1)) begin
              tx_state <= tx_pen ? S_PARITY : S_STOP;
              TxD      <= tx_pen ? tx_par : 1'b1;
            end else begin
              tx_bit <= tx_bit + BW'(1);
              tx_sh  <= tx_sh >> 1;
              TxD    <= tx_sh[1];
            end
          end
          S_PARITY: begin
            tx_state <= S_STOP;
            TxD      <= 1'b1;
          end
          default: begin
            tx_state <= S_IDLE;
            TxD      <= 1'b1;
          end
        endcase
      end
    end
  end

  // Receiver; start bit is re-checked mid-bit to reject glitches.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rx_state   <= S_IDLE;
      rx_sub     <= '0;
      rx_bit     <= '0;
      rx_sh      <= '0;
      rx_pen     <= 1'b0;
      rx_podd    <= 1'b0;
      rx_par_bit <= 1'b0;
    end else if (rx_state == S_IDLE) begin
      if (rx_fall) begin
        rx_state <= S_START;
        rx_sub   <= '0;
        rx_pen   <= ctrl[0];
        rx_podd  <= ctrl[1];
      end
    end else if (rx_state == S_START) begin
      if (tick) begin
        if (rx_sub == 4'd7) begin
          rx_sub   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s ? S_IDLE : S_DATA;
        end else begin
          rx_sub <= rx_sub + 4'd1;
        end
      end
    end else if (tick) begin
      rx_sub <= rx_sub + 4'd1;
      if (rx_sub == 4'd15) begin
        case (rx_state)
          S_DATA: begin
            rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == BW'(DATA_BITS - 1)) rx_state <= rx_pen ? S_PARITY : S_STOP;
            else rx_bit <= rx_bit + BW'(1);
          end
          S_PARITY: begin
            rx_par_bit <= rx_s;
            rx_state   <= S_STOP;
          end
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed bench for uart_fifo_core at DIV=3 (64 clocks per bit).
module tb_uart_fifo_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  add = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        ack, txd, irq;
  logic        loop = 1'b0;
  logic        rxd_drv = 1'b1;
  logic        rxd;

  int vectors = 0;
  int miscompares = 0;

  assign rxd = loop ? txd : rxd_drv;

  uart_fifo_core #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_RESET(161)) dut (
    .CLK_I(clk), .RST_I(rst), .ADD_I(add), .DAT_I(dat_i), .DAT_O(dat_o),
    .STB_I(stb), .WE_I(we), .ACK_O(ack), .RxD(rxd), .TxD(txd), .IRQ_O(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    add = a; dat_i = d; we = 1'b1; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    add = a; we = 1'b0; stb = 1'b1;
    #1 d = dat_o;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  // Samples TxD mid-bit after the start edge; bits[0]=start.
  task automatic recv_tx(input int nb, output logic [10:0] bits, output logic found);
    found = 1'b0;
    bits  = '1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    if (found) begin
      repeat (32) @(negedge clk);
      bits[0] = txd;
      for (int k = 1; k < nb; k++) begin
        repeat (64) @(negedge clk);
        bits[k] = txd;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par,
                            input logic stop);
    @(negedge clk); rxd_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = d[i];
      repeat (64) @(negedge clk);
    end
    if (use_par) begin
      rxd_drv = par;
      repeat (64) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (64) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [10:0] bits;
    logic        found;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack_idle", 32'(ack), 32'd0);
    bus_read(3'd1, r); check("rst_lsr", r, 32'h20);
    bus_read(3'd2, r); check("rst_div", r, 32'd161);
    bus_read(3'd3, r); check("rst_ctrl", r, 32'd0);
    bus_read(3'd4, r); check("rst_level", r, 32'd0);
    bus_read(3'd0, r); check("rst_data_empty", r, 32'd0);
    @(negedge clk); add = 3'd5; we = 1'b0; stb = 1'b1;
    #1 check("ack_follows_stb", 32'(ack), 32'd1);
    check("addr5_reads_zero", dat_o, 32'd0);
    @(negedge clk); stb = 1'b0;

    // T1: 0xA5, no parity
    bus_write(3'd2, 32'd3);
    bus_read(3'd2, r); check("div_rw", r, 32'd3);
    bus_write(3'd0, 32'hA5);
    recv_tx(10, bits, found);
    check("t1_found", 32'(found), 32'd1);
    check("t1_frame", 32'(bits), 32'({2'b11, 8'hA5, 1'b0}));
    repeat (40) @(negedge clk);
    check("t1_txd_idle", 32'(txd), 32'd1);
    bus_read(3'd1, r); check("t1_lsr_idle", r, 32'h20);

    // T2: loopback, odd parity
    loop = 1'b1;
    bus_write(3'd3, 32'h3);
    bus_write(3'd0, 32'h3C);
    recv_tx(11, bits, found);
    check("t2_frame", 32'(bits), 32'({2'b11, 8'h3C, 1'b0}));
    repeat (100) @(negedge clk);
    loop = 1'b0;
    bus_read(3'd1, r); check("t2_lsr", r, 32'h21);
    bus_read(3'd4, r); check("t2_level1", r, 32'd1);
    bus_read(3'd0, r); check("t2_data", r, 32'h3C);
    bus_read(3'd4, r); check("t2_level0", r, 32'd0);

    // T3: stop bit low
    bus_write(3'd3, 32'h10);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    bus_read(3'd4, r); check("t3_level", r, 32'd0);
    bus_read(3'd1, r); check("t3_lsr_fe", r, 32'h22);
    check("t3_irq_set", 32'(irq), 32'd1);
    bus_write(3'd1, 32'd0);
    bus_read(3'd1, r); check("t3_lsr_clr", r, 32'h20);
    check("t3_irq_clr", 32'(irq), 32'd0);

    // Even parity: bad parity discarded, good parity accepted
    bus_write(3'd3, 32'h1);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    bus_read(3'd1, r); check("par_err_lsr", r, 32'h24);
    bus_read(3'd4, r); check("par_err_level", r, 32'd0);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    bus_read(3'd0, r); check("par_ok_data", r, 32'h07);
    bus_write(3'd1, 32'd0);
    bus_write(3'd3, 32'd0);

    // T4: overrun
    for (int i = 0; i < 17; i++) send_frame(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    bus_read(3'd4, r); check("t4_level_full", r, 32'h10);
    bus_read(3'd1, r); check("t4_lsr_ovr", r, 32'h29);
    bus_read(3'd0, r); check("t4_first", r, 32'h40);
    bus_read(3'd0, r); check("t4_second", r, 32'h41);
    bus_read(3'd4, r); check("t4_level14", r, 32'd14);
    bus_write(3'd3, 32'hE04);
    @(negedge clk); check("t4_irq_thr_eq", 32'(irq), 32'd1);
    bus_write(3'd3, 32'hF04);
    @(negedge clk); check("t4_irq_thr_above", 32'(irq), 32'd0);

    // T5: TX FIFO overflow
    do_reset();
    bus_write(3'd2, 32'd3);
    fork
      begin
        @(negedge clk);
        add = 3'd0; we = 1'b1; stb = 1'b1;
        for (int i = 0; i < 18; i++) begin
          dat_i = 32'(8'h10 + i);
          @(negedge clk);
        end
        stb = 1'b0; we = 1'b0;
        bus_read(3'd1, r); check("t5_lsr_full", r, 32'h10);
        bus_read(3'd4, r); check("t5_level", r, 32'h0010_0000);
      end
      begin
        for (int f = 0; f < 17; f++) begin
          logic [10:0] fb;
          logic        ff;
          recv_tx(10, fb, ff);
          check($sformatf("t5_frame%0d", f), 32'({ff, fb}), 32'({1'b1, 2'b11, 8'(8'h10 + f), 1'b0}));
        end
      end
    join
    recv_tx(10, bits, found);
    check("t5_no_extra_frame", 32'(found), 32'd0);
    bus_read(3'd1, r); check("t5_lsr_idle", r, 32'h20);

    // T6: reset mid data bit
    do_reset();
    bus_write(3'd2, 32'd3);
    bus_write(3'd0, 32'h00);
    bus_write(3'd0, 32'h00);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    check("t6_start_seen", 32'(found), 32'd1);
    repeat (160) @(negedge clk);
    check("t6_mid_data_low", 32'(txd), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("t6_txd_after_rst", 32'(txd), 32'd1);
    rst = 1'b0;
    bus_read(3'd4, r); check("t6_level", r, 32'd0);
    recv_tx(10, bits, found);
    check("t6_no_frame", 32'(found), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
